uart_tx: RTL and testbench
==========================

# uart_tx

Serial UART transmitter (8N1, LSB first) that sends bytes on a single TX line at a programmable bit period of `CLKS_PER_BIT` clock cycles. It is the transmit-side counterpart of the peripheral's UART receiver and sits between the register interface and the TX pad. A one-entry holding register lets software or the bus hand over the next byte while the current frame is still shifting, so back-to-back frames leave only one idle cycle between them.

## Interface
- No parameters; the bit period is a run-time input.
- `clk_i` input 1: single clock; all logic on its rising edge.
- `rst_i` input 1: synchronous, active-high reset.
- `tx_en` input 1: transmitter enable; low acts as a synchronous clear of all state.
- `CLKS_PER_BIT` input 16: clock cycles per bit; latched at frame start; 0 is treated as 1.
- `i_TX_DV` input 1: byte-valid strobe; a byte is accepted when `i_TX_DV & o_TX_Ready`.
- `i_TX_Byte` input 8: byte to send; sampled on acceptance.
- `o_TX_Ready` output 1: holding register empty; equals `tx_en & ~hold_valid & ~rst_i`.
- `o_TX_Serial` output 1: registered serial line; idles high.
- `o_TX_Active` output 1: registered; high in START, DATA and STOP.
- `o_TX_Done` output 1: registered one-cycle pulse after a complete stop bit.

## Operation
- Internal state:
  - `hold_valid`, `hold_byte[7:0]`
  - `shift[7:0]`, `bit_idx[2:0]`
  - `clk_cnt[15:0]`, `period[15:0]`, the latched `CLKS_PER_BIT` (0 replaced by 1)
  - FSM state
- FSM states: IDLE, START, DATA, STOP, CLEANUP.
- Line level per state: IDLE=1, START=0, DATA=`shift[bit_idx]`, STOP=1, CLEANUP=1.
- Holding register:
  - On acceptance, `hold_byte` loads `i_TX_Byte` and `hold_valid` is set.
  - `hold_valid` is cleared when the FSM loads `shift` from `hold_byte`.
  - Acceptance and load cannot occur in the same cycle, because Ready=0 whenever `hold_valid`=1.
- IDLE:
  - `hold_valid`=1 → go to START; load `shift`; latch `period`; `clk_cnt`=0; `bit_idx`=0.
  - Otherwise stay in IDLE.
- START: when `clk_cnt`==`period`-1, clear `clk_cnt` and go to DATA; else increment `clk_cnt`.
- DATA:
  - At each `clk_cnt`==`period`-1, clear `clk_cnt`.
  - If `bit_idx`<7, increment `bit_idx`; otherwise go to STOP with `bit_idx`=0.
- STOP: when `clk_cnt`==`period`-1, clear `clk_cnt` and go to CLEANUP.
- CLEANUP:
  - Lasts exactly 1 cycle, with `o_TX_Done`=1 during it.
  - `hold_valid`=1 → go directly to START, loading as in IDLE.
  - Otherwise go to IDLE.
- Any undefined state encoding → IDLE.
- Width rule: `clk_cnt` comparison uses the full 16 bits, so the maximum period is 65535 cycles.
- Mid-frame changes to `CLKS_PER_BIT` have no effect until the next frame load.
- `tx_en`=0 (any state, including mid-frame), effective next cycle:
  - FSM goes to IDLE; `hold_valid` and the counters are cleared.
  - `o_TX_Serial`=1, `o_TX_Active`=0, `o_TX_Done`=0.
  - The aborted byte is discarded with no Done pulse.
- `rst_i`=1 has the same effect as `tx_en`=0 and takes priority over `tx_en` and `i_TX_DV`.

## Timing
- Reset values:
  - `o_TX_Serial`=1, `o_TX_Active`=0, `o_TX_Done`=0.
  - `o_TX_Ready`=0 while `rst_i`=1, and `tx_en` afterwards.
- Latency: byte accepted in cycle N → `hold_valid`=1 in cycle N+1 → `o_TX_Serial`=0 and `o_TX_Active`=1 from cycle N+2.
- `o_TX_Ready` returns to 1 in cycle N+2.
- Frame durations with P=`period`:
  - START: P cycles.
  - Each of the 8 data bits: P cycles.
  - STOP: P cycles.
  - CLEANUP: 1 cycle, during which `o_TX_Active`=0 and `o_TX_Done`=1.
- Single frame: the line is low at N+2 and Done is high at N+2+10P.
- Back-to-back (`hold_valid` set before CLEANUP): the next start bit begins the cycle after CLEANUP, giving a frame period of 10P+1 cycles.
- With P=1 each bit lasts 1 cycle, and the start bit follows CLEANUP with no extra gap.
- `i_TX_DV` asserted while Ready=0 is ignored; it is neither queued nor an error.

## Test plan
- Reset, `tx_en`=1, `CLKS_PER_BIT`=4, send 0xA5 at cycle 0 → expect all of:
  - `o_TX_Serial` low for cycles 2–5.
  - Data bits 1,0,1,0,0,1,0,1 in 4-cycle slots over cycles 6–37.
  - High for cycles 38–41.
  - Done=1 only at cycle 42; Active high for cycles 2–41.
- `CLKS_PER_BIT`=3, send 0x00, then 0xFF while the first frame is shifting → expect:
  - Ready drops for one accept and returns at the next load.
  - The second start bit begins exactly 31 cycles after the first; two Done pulses 31 cycles apart.
- Holding full: with a frame active and the holding register loaded, pulse `i_TX_DV` with 0x3C → byte ignored, Ready stays 0, and only the queued byte is transmitted next.
- `CLKS_PER_BIT`=8, drop `tx_en` during data bit 3 → next cycle Serial=1, Active=0, no Done pulse, holding cleared. Re-enable and send 0x81 → a clean full frame.
- Raise `rst_i` mid-STOP with `hold_valid`=1 → next cycle all outputs are at reset values; after reset no frame is emitted.
- `CLKS_PER_BIT`=0 with send 0x55 → 1-cycle bits, identical to `CLKS_PER_BIT`=1. Change `CLKS_PER_BIT` to 5 mid-frame → the current frame is unaffected, and the next frame uses 5.

Source files
------------

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, with a one-entry holding register.
// Bit period is a run-time input latched at each frame start.
module uart_tx (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        tx_en,
   input  logic [15:0] CLKS_PER_BIT,
   input  logic        i_TX_DV,
   input  logic [7:0]  i_TX_Byte,
   output logic        o_TX_Ready,
   output logic        o_TX_Serial,
   output logic        o_TX_Active,
   output logic        o_TX_Done
);

   // state     | meaning
   // ----------+------------------------------------------------------
   // S_IDLE    | line high, waiting for the holding register to fill
   // S_START   | start bit (line low) for one period
   // S_DATA    | eight data bits, LSB first, one period each
   // S_STOP    | stop bit (line high) for one period
   // S_CLEANUP | single cycle, Done pulse; chains straight into START
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_START   = 3'd1,
      S_DATA    = 3'd2,
      S_STOP    = 3'd3,
      S_CLEANUP = 3'd4
   } state_t;

   state_t      state;
   logic        hold_valid;
   logic [7:0]  hold_byte;
   logic [7:0]  shift;
   logic [2:0]  bit_idx;
   logic [2:0]  bit_nxt;
   logic [15:0] clk_cnt;
   logic [15:0] period;
   logic [15:0] period_in;
   logic        accept;
   logic        load;
   logic        bit_end;
   logic        clear;

   assign clear      = rst_i | ~tx_en;
   assign o_TX_Ready = tx_en & ~hold_valid & ~rst_i;
   assign accept     = i_TX_DV & o_TX_Ready;
   assign load       = hold_valid & ((state == S_IDLE) | (state == S_CLEANUP));
   assign bit_end    = (clk_cnt == (period - 16'd1));
   assign bit_nxt    = bit_idx + 3'd1;
   assign period_in  = (CLKS_PER_BIT == 16'd0) ? 16'd1 : CLKS_PER_BIT;

   // Ready is low whenever hold_valid is set, so accept and load never coincide.
   always_ff @(posedge clk_i) begin
      if (clear) begin
         hold_valid <= 1'b0;
         hold_byte  <= 8'h00;
      end else if (accept) begin
         hold_valid <= 1'b1;
         hold_byte  <= i_TX_Byte;
      end else if (load) begin
         hold_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (clear) begin
         state       <= S_IDLE;
         shift       <= 8'h00;
         bit_idx     <= 3'd0;
         clk_cnt     <= 16'd0;
         period      <= 16'd1;
         o_TX_Serial <= 1'b1;
         o_TX_Active <= 1'b0;
         o_TX_Done   <= 1'b0;
      end else begin
         o_TX_Done <= 1'b0;
         case (state)
            S_IDLE, S_CLEANUP: begin
               if (hold_valid) begin
                  state       <= S_START;
                  shift       <= hold_byte;
                  period      <= period_in;
                  clk_cnt     <= 16'd0;
                  bit_idx     <= 3'd0;
                  o_TX_Serial <= 1'b0;
                  o_TX_Active <= 1'b1;
               end else begin
                  state       <= S_IDLE;
                  o_TX_Serial <= 1'b1;
                  o_TX_Active <= 1'b0;
               end
            end
            S_START: begin
               if (bit_end) begin
                  clk_cnt     <= 16'd0;
                  state       <= S_DATA;
                  o_TX_Serial <= shift[0];
               end else begin
                  clk_cnt <= clk_cnt + 16'd1;
               end
            end
            S_DATA: begin
               if (bit_end) begin
                  clk_cnt <= 16'd0;
                  if (bit_idx != 3'd7) begin
                     bit_idx     <= bit_nxt;
                     o_TX_Serial <= shift[bit_nxt];
                  end else begin
                     bit_idx     <= 3'd0;
                     state       <= S_STOP;
                     o_TX_Serial <= 1'b1;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 16'd1;
               end
            end
            S_STOP: begin
               if (bit_end) begin
                  clk_cnt     <= 16'd0;
                  state       <= S_CLEANUP;
                  o_TX_Serial <= 1'b1;
                  o_TX_Active <= 1'b0;
                  o_TX_Done   <= 1'b1;
               end else begin
                  clk_cnt <= clk_cnt + 16'd1;
               end
            end
            default: begin
               state       <= S_IDLE;
               clk_cnt     <= 16'd0;
               bit_idx     <= 3'd0;
               o_TX_Serial <= 1'b1;
               o_TX_Active <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: waveform vectors captured per cycle and
// compared against frames built from the byte and bit period.
module tb_uart_tx;

   logic        clk_i;
   logic        rst_i;
   logic        tx_en;
   logic [15:0] CLKS_PER_BIT;
   logic        i_TX_DV;
   logic [7:0]  i_TX_Byte;
   logic        o_TX_Ready;
   logic        o_TX_Serial;
   logic        o_TX_Active;
   logic        o_TX_Done;

   int n_cmp;
   int n_bad;

   uart_tx dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .tx_en        (tx_en),
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .i_TX_DV      (i_TX_DV),
      .i_TX_Byte    (i_TX_Byte),
      .o_TX_Ready   (o_TX_Ready),
      .o_TX_Serial  (o_TX_Serial),
      .o_TX_Active  (o_TX_Active),
      .o_TX_Done    (o_TX_Done)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_gap(input int n);
      i_TX_DV = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   // Expected line level at cycle k for a frame whose start bit begins at cycle s.
   function automatic logic frame_line(input logic [7:0] b, input int p, input int s, input int k);
      int o;
      o = k - s;
      if (o < 0) return 1'b1;
      if (o < p) return 1'b0;
      if (o < 9 * p) return b[(o - p) / p];
      return 1'b1;
   endfunction

   task automatic run_single(input string tag, input logic [7:0] b, input logic [15:0] cpb, input int p);
      logic [127:0] gs, ga, gd, es, ea, ed;
      int n;
      n  = 2 + 10 * p + 4;
      gs = '0; ga = '0; gd = '0; es = '0; ea = '0; ed = '0;
      CLKS_PER_BIT = cpb;
      for (int k = 0; k < n; k++) begin
         gs[k] = o_TX_Serial;
         ga[k] = o_TX_Active;
         gd[k] = o_TX_Done;
         es[k] = frame_line(b, p, 2, k);
         ea[k] = (k >= 2) && (k < 2 + 10 * p);
         ed[k] = (k == 2 + 10 * p);
         i_TX_DV   = (k == 0);
         i_TX_Byte = b;
         tick();
      end
      i_TX_DV = 1'b0;
      check({tag, "_serial"}, gs, es);
      check({tag, "_active"}, ga, ea);
      check({tag, "_done"},   gd, ed);
   endtask

   // Two frames: b1 sent at cycle 0, b2 queued at t2, optional ignored byte at tj,
   // optional bit-period change at tc.
   task automatic run_pair(input string tag, input logic [7:0] b1, input logic [7:0] b2,
                           input logic [15:0] cpb1, input logic [15:0] cpb2,
                           input int p1, input int p2, input int t2, input int tj, input int tc);
      logic [127:0] gs, ga, gd, gr, es, ea, ed, er;
      int s2, n;
      s2 = 2 + 10 * p1 + 1;
      n  = s2 + 10 * p2 + 4;
      gs = '0; ga = '0; gd = '0; gr = '0; es = '0; ea = '0; ed = '0; er = '0;
      CLKS_PER_BIT = cpb1;
      for (int k = 0; k < n; k++) begin
         gs[k] = o_TX_Serial;
         ga[k] = o_TX_Active;
         gd[k] = o_TX_Done;
         gr[k] = o_TX_Ready;
         es[k] = (k < s2) ? frame_line(b1, p1, 2, k) : frame_line(b2, p2, s2, k);
         ea[k] = ((k >= 2) && (k < 2 + 10 * p1)) || ((k >= s2) && (k < s2 + 10 * p2));
         ed[k] = (k == 2 + 10 * p1) || (k == s2 + 10 * p2);
         er[k] = !((k == 1) || ((k > t2) && (k < s2)));
         i_TX_DV = (k == 0) || (k == t2) || (k == tj);
         if (k == 0)       i_TX_Byte = b1;
         else if (k == t2) i_TX_Byte = b2;
         else              i_TX_Byte = 8'h3C;
         if (k == tc) CLKS_PER_BIT = cpb2;
         tick();
      end
      i_TX_DV = 1'b0;
      check({tag, "_serial"}, gs, es);
      check({tag, "_active"}, ga, ea);
      check({tag, "_done"},   gd, ed);
      check({tag, "_ready"},  gr, er);
   endtask

   initial begin
      logic seen;
      n_cmp        = 0;
      n_bad        = 0;
      rst_i        = 1'b1;
      tx_en        = 1'b1;
      CLKS_PER_BIT = 16'd4;
      i_TX_DV      = 1'b0;
      i_TX_Byte    = 8'h00;

      // reset values
      tick(); tick();
      check("rst_serial", {127'd0, o_TX_Serial}, 128'd1);
      check("rst_active", {127'd0, o_TX_Active}, 128'd0);
      check("rst_done",   {127'd0, o_TX_Done},   128'd0);
      check("rst_ready",  {127'd0, o_TX_Ready},  128'd0);
      rst_i = 1'b0;
      tick();
      check("post_rst_ready", {127'd0, o_TX_Ready}, 128'd1);

      // single 0xA5 frame, P=4
      run_single("a5_p4", 8'hA5, 16'd4, 4);
      idle_gap(3);

      // back-to-back 0x00 then 0xFF, P=3: 31-cycle frame period
      run_pair("b2b_p3", 8'h00, 8'hFF, 16'd3, 16'd3, 3, 3, 5, -1, -1);
      idle_gap(3);

      // holding full: 0x3C pulsed while Ready=0 must be dropped
      run_pair("hold_full", 8'h12, 8'h34, 16'd3, 16'd3, 3, 3, 5, 10, -1);
      idle_gap(3);

      // tx_en dropped during data bit 3 (cycles 34..41 at P=8) with a byte queued
      CLKS_PER_BIT = 16'd8;
      seen = 1'b0;
      for (int k = 0; k < 37; k++) begin
         seen |= o_TX_Done;
         i_TX_DV   = (k == 0) || (k == 5);
         i_TX_Byte = (k == 0) ? 8'h5A : 8'hC3;
         if (k == 36) begin
            check("abort_active_before", {127'd0, o_TX_Active}, 128'd1);
            tx_en = 1'b0;
         end
         tick();
      end
      i_TX_DV = 1'b0;
      check("abort_serial", {127'd0, o_TX_Serial}, 128'd1);
      check("abort_active", {127'd0, o_TX_Active}, 128'd0);
      check("abort_ready",  {127'd0, o_TX_Ready},  128'd0);
      for (int k = 0; k < 8; k++) begin
         seen |= o_TX_Done;
         tick();
      end
      tx_en = 1'b1;
      tick();
      check("reen_ready", {127'd0, o_TX_Ready}, 128'd1);
      for (int k = 0; k < 30; k++) begin
         seen |= o_TX_Done | ~o_TX_Serial | o_TX_Active;
         tick();
      end
      check("abort_no_frame", {127'd0, seen}, 128'd0);
      run_single("reen_81", 8'h81, 16'd8, 8);
      idle_gap(3);

      // rst_i mid-STOP (cycles 20..21 at P=2) with a byte queued
      CLKS_PER_BIT = 16'd2;
      for (int k = 0; k < 21; k++) begin
         i_TX_DV   = (k == 0) || (k == 4);
         i_TX_Byte = (k == 0) ? 8'h11 : 8'h22;
         if (k == 20) begin
            check("stop_active_before", {127'd0, o_TX_Active}, 128'd1);
            rst_i = 1'b1;
         end
         tick();
      end
      i_TX_DV = 1'b0;
      check("rst_mid_serial", {127'd0, o_TX_Serial}, 128'd1);
      check("rst_mid_active", {127'd0, o_TX_Active}, 128'd0);
      check("rst_mid_done",   {127'd0, o_TX_Done},   128'd0);
      check("rst_mid_ready",  {127'd0, o_TX_Ready},  128'd0);
      rst_i = 1'b0;
      seen  = 1'b0;
      for (int k = 0; k < 30; k++) begin
         tick();
         seen |= o_TX_Done | ~o_TX_Serial | o_TX_Active;
      end
      check("rst_no_frame", {127'd0, seen}, 128'd0);

      // zero period behaves as one; period change mid-frame applies to the next frame
      run_single("cpb0_55", 8'h55, 16'd0, 1);
      idle_gap(3);
      run_single("cpb1_55", 8'h55, 16'd1, 1);
      idle_gap(3);
      run_pair("cpb_change", 8'h96, 8'h69, 16'd3, 16'd5, 3, 5, 5, -1, 8);
      idle_gap(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
